// File: rtl/axi_read_arbiter.sv
// Two-to-one AXI read arbiter: icache (requester 0) and dcache (requester 1) share
// one downstream AR/R port, round-robin on ties, grant held from AR through rlast.
module axi_read_arbiter #(
  parameter int ID_WIDTH   = 13,
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  reset,

  input  logic [ID_WIDTH-1:0]   icache_m_axi_arid,
  input  logic [ADDR_WIDTH-1:0] icache_m_axi_araddr,
  input  logic [7:0]            icache_m_axi_arlen,
  input  logic [2:0]            icache_m_axi_arsize,
  input  logic [1:0]            icache_m_axi_arburst,
  input  logic                  icache_m_axi_arlock,
  input  logic [3:0]            icache_m_axi_arcache,
  input  logic [2:0]            icache_m_axi_arprot,
  input  logic                  icache_m_axi_arvalid,
  output logic                  icache_m_axi_arready,
  output logic [ID_WIDTH-1:0]   icache_m_axi_rid,
  output logic [DATA_WIDTH-1:0] icache_m_axi_rdata,
  output logic [1:0]            icache_m_axi_rresp,
  output logic                  icache_m_axi_rlast,
  output logic                  icache_m_axi_rvalid,
  input  logic                  icache_m_axi_rready,

  input  logic [ID_WIDTH-1:0]   dcache_m_axi_arid,
  input  logic [ADDR_WIDTH-1:0] dcache_m_axi_araddr,
  input  logic [7:0]            dcache_m_axi_arlen,
  input  logic [2:0]            dcache_m_axi_arsize,
  input  logic [1:0]            dcache_m_axi_arburst,
  input  logic                  dcache_m_axi_arlock,
  input  logic [3:0]            dcache_m_axi_arcache,
  input  logic [2:0]            dcache_m_axi_arprot,
  input  logic                  dcache_m_axi_arvalid,
  output logic                  dcache_m_axi_arready,
  output logic [ID_WIDTH-1:0]   dcache_m_axi_rid,
  output logic [DATA_WIDTH-1:0] dcache_m_axi_rdata,
  output logic [1:0]            dcache_m_axi_rresp,
  output logic                  dcache_m_axi_rlast,
  output logic                  dcache_m_axi_rvalid,
  input  logic                  dcache_m_axi_rready,

  output logic [ID_WIDTH-1:0]   m_axi_arid,
  output logic [ADDR_WIDTH-1:0] m_axi_araddr,
  output logic [7:0]            m_axi_arlen,
  output logic [2:0]            m_axi_arsize,
  output logic [1:0]            m_axi_arburst,
  output logic                  m_axi_arlock,
  output logic [3:0]            m_axi_arcache,
  output logic [2:0]            m_axi_arprot,
  output logic                  m_axi_arvalid,
  input  logic                  m_axi_arready,
  input  logic [ID_WIDTH-1:0]   m_axi_rid,
  input  logic [DATA_WIDTH-1:0] m_axi_rdata,
  input  logic [1:0]            m_axi_rresp,
  input  logic                  m_axi_rlast,
  input  logic                  m_axi_rvalid,
  output logic                  m_axi_rready,

  output logic                  rresp_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } state_t;

  state_t     state_reg, state_next;
  logic       grant_reg, grant_next;
  logic       last_grant_reg, last_grant_next;
  logic [8:0] beats_reg, beats_next;
  logic       rresp_err_reg, rresp_err_next;

  // Requester-indexed views of the two cache ports (index 0 = icache, 1 = dcache)
  logic [1:0]            req_arvalid;
  logic [1:0]            req_arready;
  logic [1:0]            req_rvalid;
  logic [1:0]            req_rready;
  logic [ID_WIDTH-1:0]   req_arid    [2];
  logic [ADDR_WIDTH-1:0] req_araddr  [2];
  logic [7:0]            req_arlen   [2];
  logic [2:0]            req_arsize  [2];
  logic [1:0]            req_arburst [2];
  logic                  req_arlock  [2];
  logic [3:0]            req_arcache [2];
  logic [2:0]            req_arprot  [2];

  logic ar_phase;
  logic r_phase;
  logic ar_fire;
  logic r_fire;

  assign req_arvalid = {dcache_m_axi_arvalid, icache_m_axi_arvalid};
  assign req_rready  = {dcache_m_axi_rready, icache_m_axi_rready};

  assign req_arid[0]    = icache_m_axi_arid;
  assign req_araddr[0]  = icache_m_axi_araddr;
  assign req_arlen[0]   = icache_m_axi_arlen;
  assign req_arsize[0]  = icache_m_axi_arsize;
  assign req_arburst[0] = icache_m_axi_arburst;
  assign req_arlock[0]  = icache_m_axi_arlock;
  assign req_arcache[0] = icache_m_axi_arcache;
  assign req_arprot[0]  = icache_m_axi_arprot;

  assign req_arid[1]    = dcache_m_axi_arid;
  assign req_araddr[1]  = dcache_m_axi_araddr;
  assign req_arlen[1]   = dcache_m_axi_arlen;
  assign req_arsize[1]  = dcache_m_axi_arsize;
  assign req_arburst[1] = dcache_m_axi_arburst;
  assign req_arlock[1]  = dcache_m_axi_arlock;
  assign req_arcache[1] = dcache_m_axi_arcache;
  assign req_arprot[1]  = dcache_m_axi_arprot;

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= IDLE;
      grant_reg      <= 1'b0;
      last_grant_reg <= 1'b1;
      beats_reg      <= 9'd0;
      rresp_err_reg  <= 1'b0;
    end else begin
      state_reg      <= state_next;
      grant_reg      <= grant_next;
      last_grant_reg <= last_grant_next;
      beats_reg      <= beats_next;
      rresp_err_reg  <= rresp_err_next;
    end
  end

  assign ar_fire = m_axi_arvalid && m_axi_arready;
  assign r_fire  = m_axi_rvalid && m_axi_rready;

  // Next-state logic
  always_comb begin
    state_next      = state_reg;
    grant_next      = grant_reg;
    last_grant_next = last_grant_reg;
    beats_next      = beats_reg;
    rresp_err_next  = rresp_err_reg;
    unique case (state_reg)
      IDLE: begin
        if (|req_arvalid) begin
          state_next = ADDR;
          // On a tie the requester that did not win last time goes first
          if (&req_arvalid) begin
            grant_next = ~last_grant_reg;
          end else begin
            grant_next = req_arvalid[1];
          end
        end
      end
      ADDR: begin
        if (ar_fire) begin
          state_next = DATA;
          beats_next = 9'd0;
        end
      end
      DATA: begin
        if (r_fire) begin
          beats_next = beats_reg + 9'd1;
          if (m_axi_rresp != 2'b00) begin
            rresp_err_next = 1'b1;
          end
          // Only rlast ends the burst; the beat counter is informational
          if (m_axi_rlast) begin
            last_grant_next = grant_reg;
            state_next      = IDLE;
          end
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Output logic
  always_comb begin
    ar_phase      = 1'b0;
    r_phase       = 1'b0;
    m_axi_arvalid = 1'b0;
    m_axi_rready  = 1'b0;
    unique case (state_reg)
      ADDR: begin
        ar_phase      = 1'b1;
        m_axi_arvalid = req_arvalid[grant_reg];
      end
      DATA: begin
        r_phase      = 1'b1;
        m_axi_rready = req_rready[grant_reg];
      end
      default: begin
        ar_phase = 1'b0;
      end
    endcase
  end

  // Per-requester handshake demux: only the granted side sees downstream handshakes
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_req
      assign req_arready[gi] = ar_phase && (grant_reg == 1'(gi)) && m_axi_arready;
      assign req_rvalid[gi]  = r_phase && (grant_reg == 1'(gi)) && m_axi_rvalid;
    end
  endgenerate

  // AR payload passes straight through from the granted requester
  assign m_axi_arid    = req_arid[grant_reg];
  assign m_axi_araddr  = req_araddr[grant_reg];
  assign m_axi_arlen   = req_arlen[grant_reg];
  assign m_axi_arsize  = req_arsize[grant_reg];
  assign m_axi_arburst = req_arburst[grant_reg];
  assign m_axi_arlock  = req_arlock[grant_reg];
  assign m_axi_arcache = req_arcache[grant_reg];
  assign m_axi_arprot  = req_arprot[grant_reg];

  assign icache_m_axi_arready = req_arready[0];
  assign dcache_m_axi_arready = req_arready[1];
  assign icache_m_axi_rvalid  = req_rvalid[0];
  assign dcache_m_axi_rvalid  = req_rvalid[1];

  // R payload is broadcast; rvalid alone qualifies it per requester
  assign icache_m_axi_rid   = m_axi_rid;
  assign icache_m_axi_rdata = m_axi_rdata;
  assign icache_m_axi_rresp = m_axi_rresp;
  assign icache_m_axi_rlast = m_axi_rlast;
  assign dcache_m_axi_rid   = m_axi_rid;
  assign dcache_m_axi_rdata = m_axi_rdata;
  assign dcache_m_axi_rresp = m_axi_rresp;
  assign dcache_m_axi_rlast = m_axi_rlast;

  assign rresp_err = rresp_err_reg;

endmodule

// File: tb/tb_axi_read_arbiter.sv
// Directed bench for axi_read_arbiter: ties, hold-off, AR stall, R backpressure,
// sticky error flag and mid-burst reset.
module tb_axi_read_arbiter;

  localparam int ID_WIDTH   = 13;
  localparam int ADDR_WIDTH = 64;
  localparam int DATA_WIDTH = 64;
  localparam logic [ID_WIDTH-1:0] IC_ID = 13'h00a5;
  localparam logic [ID_WIDTH-1:0] DC_ID = 13'h1b33;
  localparam logic [63:0] IC_ADDR = 64'h0000_0000_1000_0000;
  localparam logic [63:0] DC_ADDR = 64'h0000_0000_8000_4000;

  logic clk;
  logic reset;

  logic [ID_WIDTH-1:0]   icache_m_axi_arid, dcache_m_axi_arid;
  logic [ADDR_WIDTH-1:0] icache_m_axi_araddr, dcache_m_axi_araddr;
  logic [7:0]            icache_m_axi_arlen, dcache_m_axi_arlen;
  logic [2:0]            icache_m_axi_arsize, dcache_m_axi_arsize;
  logic [1:0]            icache_m_axi_arburst, dcache_m_axi_arburst;
  logic                  icache_m_axi_arlock, dcache_m_axi_arlock;
  logic [3:0]            icache_m_axi_arcache, dcache_m_axi_arcache;
  logic [2:0]            icache_m_axi_arprot, dcache_m_axi_arprot;
  logic                  icache_m_axi_arvalid, dcache_m_axi_arvalid;
  logic                  icache_m_axi_arready, dcache_m_axi_arready;
  logic [ID_WIDTH-1:0]   icache_m_axi_rid, dcache_m_axi_rid;
  logic [DATA_WIDTH-1:0] icache_m_axi_rdata, dcache_m_axi_rdata;
  logic [1:0]            icache_m_axi_rresp, dcache_m_axi_rresp;
  logic                  icache_m_axi_rlast, dcache_m_axi_rlast;
  logic                  icache_m_axi_rvalid, dcache_m_axi_rvalid;
  logic                  icache_m_axi_rready, dcache_m_axi_rready;

  logic [ID_WIDTH-1:0]   m_axi_arid;
  logic [ADDR_WIDTH-1:0] m_axi_araddr;
  logic [7:0]            m_axi_arlen;
  logic [2:0]            m_axi_arsize;
  logic [1:0]            m_axi_arburst;
  logic                  m_axi_arlock;
  logic [3:0]            m_axi_arcache;
  logic [2:0]            m_axi_arprot;
  logic                  m_axi_arvalid;
  logic                  m_axi_arready;
  logic [ID_WIDTH-1:0]   m_axi_rid;
  logic [DATA_WIDTH-1:0] m_axi_rdata;
  logic [1:0]            m_axi_rresp;
  logic                  m_axi_rlast;
  logic                  m_axi_rvalid;
  logic                  m_axi_rready;
  logic                  rresp_err;

  int total = 0;
  int bad   = 0;
  logic exp_err = 1'b0;

  axi_read_arbiter #(
    .ID_WIDTH(ID_WIDTH), .ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH)
  ) dut (
    .clk(clk), .reset(reset),
    .icache_m_axi_arid(icache_m_axi_arid), .icache_m_axi_araddr(icache_m_axi_araddr),
    .icache_m_axi_arlen(icache_m_axi_arlen), .icache_m_axi_arsize(icache_m_axi_arsize),
    .icache_m_axi_arburst(icache_m_axi_arburst), .icache_m_axi_arlock(icache_m_axi_arlock),
    .icache_m_axi_arcache(icache_m_axi_arcache), .icache_m_axi_arprot(icache_m_axi_arprot),
    .icache_m_axi_arvalid(icache_m_axi_arvalid), .icache_m_axi_arready(icache_m_axi_arready),
    .icache_m_axi_rid(icache_m_axi_rid), .icache_m_axi_rdata(icache_m_axi_rdata),
    .icache_m_axi_rresp(icache_m_axi_rresp), .icache_m_axi_rlast(icache_m_axi_rlast),
    .icache_m_axi_rvalid(icache_m_axi_rvalid), .icache_m_axi_rready(icache_m_axi_rready),
    .dcache_m_axi_arid(dcache_m_axi_arid), .dcache_m_axi_araddr(dcache_m_axi_araddr),
    .dcache_m_axi_arlen(dcache_m_axi_arlen), .dcache_m_axi_arsize(dcache_m_axi_arsize),
    .dcache_m_axi_arburst(dcache_m_axi_arburst), .dcache_m_axi_arlock(dcache_m_axi_arlock),
    .dcache_m_axi_arcache(dcache_m_axi_arcache), .dcache_m_axi_arprot(dcache_m_axi_arprot),
    .dcache_m_axi_arvalid(dcache_m_axi_arvalid), .dcache_m_axi_arready(dcache_m_axi_arready),
    .dcache_m_axi_rid(dcache_m_axi_rid), .dcache_m_axi_rdata(dcache_m_axi_rdata),
    .dcache_m_axi_rresp(dcache_m_axi_rresp), .dcache_m_axi_rlast(dcache_m_axi_rlast),
    .dcache_m_axi_rvalid(dcache_m_axi_rvalid), .dcache_m_axi_rready(dcache_m_axi_rready),
    .m_axi_arid(m_axi_arid), .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen),
    .m_axi_arsize(m_axi_arsize), .m_axi_arburst(m_axi_arburst), .m_axi_arlock(m_axi_arlock),
    .m_axi_arcache(m_axi_arcache), .m_axi_arprot(m_axi_arprot),
    .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
    .m_axi_rid(m_axi_rid), .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
    .m_axi_rlast(m_axi_rlast), .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready),
    .rresp_err(rresp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Handshake outputs packed for one-shot "all quiet" checks
  function automatic logic [5:0] hs_vec();
    return {m_axi_arvalid, m_axi_rready, icache_m_axi_arready, dcache_m_axi_arready,
            icache_m_axi_rvalid, dcache_m_axi_rvalid};
  endfunction

  task automatic set_arvalid(input int g, input logic v);
    if (g == 0) icache_m_axi_arvalid = v;
    else        dcache_m_axi_arvalid = v;
  endtask

  // Entered at a negedge in IDLE; returns at the negedge of the cycle after rlast.
  task automatic burst(input int g, input int len, input int ar_stall, input bit toggle,
                       input int err_idx, input bit raise_other);
    logic [63:0]         a;
    logic [ID_WIDTH-1:0] id;
    logic                rr;
    int                  beat;
    bit                  done;
    a  = (g == 0) ? IC_ADDR : DC_ADDR;
    id = (g == 0) ? IC_ID : DC_ID;
    if (g == 0) icache_m_axi_arlen = 8'(len);
    else        dcache_m_axi_arlen = 8'(len);
    set_arvalid(g, 1'b1);
    #1;
    chk("idle_arvalid", 64'(m_axi_arvalid), 64'd0);
    @(negedge clk);
    for (int k = 0; k <= ar_stall; k++) begin
      m_axi_arready = (k == ar_stall);
      #1;
      chk("ar_valid", 64'(m_axi_arvalid), 64'd1);
      chk("ar_addr", m_axi_araddr, a);
      chk("ar_id", 64'(m_axi_arid), 64'(id));
      chk("ar_len", 64'(m_axi_arlen), 64'(len));
      chk("ar_size", 64'(m_axi_arsize), (g == 0) ? 64'd3 : 64'd2);
      chk("ar_ready_granted", 64'((g == 0) ? icache_m_axi_arready : dcache_m_axi_arready),
          64'(k == ar_stall));
      chk("ar_ready_other", 64'((g == 0) ? dcache_m_axi_arready : icache_m_axi_arready), 64'd0);
      @(negedge clk);
    end
    m_axi_arready = 1'b0;
    set_arvalid(g, 1'b0);
    beat = 0;
    done = 1'b0;
    for (int cyc = 0; cyc < 64 && !done; cyc++) begin
      rr = toggle ? cyc[0] : 1'b1;
      if (g == 0) begin icache_m_axi_rready = rr; dcache_m_axi_rready = ~rr; end
      else        begin dcache_m_axi_rready = rr; icache_m_axi_rready = ~rr; end
      if (raise_other && cyc == 2) set_arvalid(1 - g, 1'b1);
      m_axi_rvalid = 1'b1;
      m_axi_rid    = id;
      m_axi_rdata  = a + 64'(beat);
      m_axi_rlast  = (beat == len);
      m_axi_rresp  = (beat == err_idx) ? 2'd2 : 2'd0;
      #1;
      chk("r_valid_granted", 64'((g == 0) ? icache_m_axi_rvalid : dcache_m_axi_rvalid), 64'd1);
      chk("r_valid_other", 64'((g == 0) ? dcache_m_axi_rvalid : icache_m_axi_rvalid), 64'd0);
      chk("r_data", (g == 0) ? icache_m_axi_rdata : dcache_m_axi_rdata, a + 64'(beat));
      chk("r_last", 64'((g == 0) ? icache_m_axi_rlast : dcache_m_axi_rlast), 64'(beat == len));
      chk("m_rready", 64'(m_axi_rready), 64'(rr));
      chk("ar_holdoff", 64'({icache_m_axi_arready, dcache_m_axi_arready}), 64'd0);
      chk("rresp_err", 64'(rresp_err), 64'(exp_err));
      if (rr) begin
        if (beat == err_idx) exp_err = 1'b1;
        if (beat == len) done = 1'b1;
        beat++;
      end
      @(negedge clk);
    end
    if (!done) chk("burst_timeout", 64'd0, 64'd1);
    chk("beat_count", 64'(beat), 64'(len + 1));
    // Downstream rvalid is left high here: the block must already be in IDLE and ignore it
    #1;
    chk("post_rlast_quiet", 64'({icache_m_axi_rvalid, dcache_m_axi_rvalid, m_axi_rready}), 64'd0);
    chk("post_rlast_err", 64'(rresp_err), 64'(exp_err));
    m_axi_rvalid = 1'b0;
    m_axi_rlast  = 1'b0;
    m_axi_rresp  = 2'd0;
    $display("burst req=%0d len=%0d ar_stall=%0d toggle=%0d beats=%0d err=%0d",
             g, len, ar_stall, toggle, beat, rresp_err);
  endtask

  initial begin
    reset = 1'b1;
    icache_m_axi_arid = IC_ID;  icache_m_axi_araddr = IC_ADDR;  icache_m_axi_arlen = 8'd0;
    icache_m_axi_arsize = 3'd3; icache_m_axi_arburst = 2'd1; icache_m_axi_arlock = 1'b0;
    icache_m_axi_arcache = 4'h2; icache_m_axi_arprot = 3'd4; icache_m_axi_arvalid = 1'b0;
    icache_m_axi_rready = 1'b0;
    dcache_m_axi_arid = DC_ID;  dcache_m_axi_araddr = DC_ADDR;  dcache_m_axi_arlen = 8'd0;
    dcache_m_axi_arsize = 3'd2; dcache_m_axi_arburst = 2'd1; dcache_m_axi_arlock = 1'b0;
    dcache_m_axi_arcache = 4'hf; dcache_m_axi_arprot = 3'd0; dcache_m_axi_arvalid = 1'b0;
    dcache_m_axi_rready = 1'b0;
    m_axi_arready = 1'b0; m_axi_rid = '0; m_axi_rdata = '0; m_axi_rresp = 2'd0;
    m_axi_rlast = 1'b0; m_axi_rvalid = 1'b0;

    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("reset_handshakes", 64'(hs_vec()), 64'd0);
    chk("reset_err", 64'(rresp_err), 64'd0);

    // Ties out of reset alternate icache, dcache, icache, dcache
    dcache_m_axi_arvalid = 1'b1;
    burst(0, 1, 0, 1'b0, -1, 1'b0);
    burst(1, 1, 0, 1'b0, -1, 1'b0);
    dcache_m_axi_arvalid = 1'b1;
    burst(0, 2, 0, 1'b0, -1, 1'b0);
    burst(1, 0, 0, 1'b0, -1, 1'b0);

    // Lone icache 8-beat burst
    burst(0, 7, 0, 1'b0, -1, 1'b0);

    // dcache arrives mid-burst, then its AR stalls 5 cycles with toggled rready
    burst(0, 3, 0, 1'b0, -1, 1'b1);
    burst(1, 3, 5, 1'b1, -1, 1'b0);

    // Error on beat 3, then a clean burst keeps the flag set
    burst(0, 7, 0, 1'b0, 3, 1'b0);
    burst(1, 2, 0, 1'b0, -1, 1'b0);

    // Reset in the middle of an icache burst
    icache_m_axi_arlen = 8'd7;
    icache_m_axi_arvalid = 1'b1;
    @(negedge clk);
    m_axi_arready = 1'b1;
    @(negedge clk);
    m_axi_arready = 1'b0;
    icache_m_axi_arvalid = 1'b0;
    icache_m_axi_rready = 1'b1;
    m_axi_rvalid = 1'b1;
    m_axi_rdata = IC_ADDR;
    @(negedge clk);
    m_axi_rdata = IC_ADDR + 64'd1;
    @(negedge clk);
    #1;
    chk("pre_reset_rvalid", 64'(icache_m_axi_rvalid), 64'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    exp_err = 1'b0;
    #1;
    chk("midburst_reset_handshakes", 64'(hs_vec()), 64'd0);
    chk("midburst_reset_err", 64'(rresp_err), 64'd0);
    $display("reset mid-burst handshakes=%0h err=%0d", hs_vec(), rresp_err);
    m_axi_rvalid = 1'b0;

    // First tie after reset goes to icache again
    dcache_m_axi_arvalid = 1'b1;
    burst(0, 1, 0, 1'b0, -1, 1'b0);
    burst(1, 1, 0, 1'b0, -1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
